lottery_bus_arbiter: RTL and testbench

//  Lottery-scheduled bus arbiter for 4 masters of the AHB lottery subsystem.

---
 rtl/lottery_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_lottery_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lottery_bus_arbiter.sv
// Lottery-scheduled bus arbiter for four masters. Requests and tickets are snapshotted,
// a ticket-weighted draw picks the winner, and repeated misses fall back to fixed priority.
module lottery_bus_arbiter #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         MAX_HOLD  = 16,
    parameter int         MAX_DRAW  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] t0,
    input  logic [3:0] t1,
    input  logic [3:0] t2,
    input  logic [3:0] t3,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       fallback
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [3:0] MAX_DRAW_C = 4'(MAX_DRAW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    // x^8+x^6+x^5+x^4+1; the all-zero state is unreachable from a nonzero seed
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        lfsr_next = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    state_t     state_q;
    logic [7:0] lfsr_q;
    logic [3:0] snap_req_q;
    logic [3:0] snap_t0_q, snap_t1_q, snap_t2_q, snap_t3_q;
    logic [3:0] draw_cnt_q;
    logic [7:0] hold_cnt_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;
    logic       fallback_q;

    logic [3:0] gated0_s, gated1_s, gated2_s, gated3_s;
    logic       tickets_zero_s;
    logic [4:0] h0_s, h1_s, h2_s, h3_s;
    logic [5:0] s0_s, s1_s, s2_s, s3_s;
    logic [5:0] r_s;
    logic       hit_s;
    logic [1:0] lot_id_s;
    logic [1:0] fb_id_s;
    logic       release_s;

    // Ticket prefix sums over the snapshot, lottery winner and fallback winner
    always_comb begin
        gated0_s       = snap_req_q[0] ? snap_t0_q : 4'd0;
        gated1_s       = snap_req_q[1] ? snap_t1_q : 4'd0;
        gated2_s       = snap_req_q[2] ? snap_t2_q : 4'd0;
        gated3_s       = snap_req_q[3] ? snap_t3_q : 4'd0;
        tickets_zero_s = ((gated0_s | gated1_s | gated2_s | gated3_s) == 4'd0);
        h0_s = tickets_zero_s ? {4'd0, snap_req_q[0]} : {1'b0, gated0_s};
        h1_s = tickets_zero_s ? {4'd0, snap_req_q[1]} : {1'b0, gated1_s};
        h2_s = tickets_zero_s ? {4'd0, snap_req_q[2]} : {1'b0, gated2_s};
        h3_s = tickets_zero_s ? {4'd0, snap_req_q[3]} : {1'b0, gated3_s};
        s0_s  = {1'b0, h0_s};
        s1_s  = s0_s + {1'b0, h1_s};
        s2_s  = s1_s + {1'b0, h2_s};
        s3_s  = s2_s + {1'b0, h3_s};
        r_s   = lfsr_q[5:0];
        hit_s = (r_s < s3_s);
        if (r_s < s0_s) begin
            lot_id_s = 2'd0;
        end else if (r_s < s1_s) begin
            lot_id_s = 2'd1;
        end else if (r_s < s2_s) begin
            lot_id_s = 2'd2;
        end else begin
            lot_id_s = 2'd3;
        end
        // Fallback only considers requesters that hold tickets, so zero-ticket
        // masters stay locked out whenever someone else has tickets.
        if (h0_s != 5'd0) begin
            fb_id_s = 2'd0;
        end else if (h1_s != 5'd0) begin
            fb_id_s = 2'd1;
        end else if (h2_s != 5'd0) begin
            fb_id_s = 2'd2;
        end else begin
            fb_id_s = 2'd3;
        end
        release_s = done | ~req[gnt_id_q] | (hold_cnt_q == MAX_HOLD_C);
    end

    // Arbitration FSM with LFSR, snapshot registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= LFSR_SEED;
            snap_req_q <= 4'd0;
            snap_t0_q  <= 4'd0;
            snap_t1_q  <= 4'd0;
            snap_t2_q  <= 4'd0;
            snap_t3_q  <= 4'd0;
            draw_cnt_q <= 4'd0;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 4'd0;
            gnt_id_q   <= 2'd0;
            busy_q     <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_next(lfsr_q);
            fallback_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gnt_q      <= 4'd0;
                    busy_q     <= 1'b0;
                    draw_cnt_q <= 4'd0;
                    hold_cnt_q <= 8'd0;
                    if (|req) begin
                        snap_req_q <= req;
                        snap_t0_q  <= t0;
                        snap_t1_q  <= t1;
                        snap_t2_q  <= t2;
                        snap_t3_q  <= t3;
                        state_q    <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (draw_cnt_q == MAX_DRAW_C) begin
                        gnt_q      <= onehot(fb_id_s);
                        gnt_id_q   <= fb_id_s;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= 8'd1;
                        fallback_q <= 1'b1;
                        state_q    <= ST_GRANT;
                    end else if (hit_s) begin
                        gnt_q      <= onehot(lot_id_s);
                        gnt_id_q   <= lot_id_s;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= 8'd1;
                        state_q    <= ST_GRANT;
                    end else begin
                        draw_cnt_q <= draw_cnt_q + 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        gnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    gnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = busy_q;
    assign fallback = fallback_q;

endmodule

// File: tb/tb_lottery_bus_arbiter.sv
// Directed bench for lottery_bus_arbiter; draw outcomes are predicted from an LFSR model
// that tracks the clock from reset, and a few cases are checked against hand-derived values.
module tb_lottery_bus_arbiter;

    localparam int MAX_DRAW = 4;
    localparam int MAX_HOLD = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'd0;
    logic [3:0] t0    = 4'd0;
    logic [3:0] t1    = 4'd0;
    logic [3:0] t2    = 4'd0;
    logic [3:0] t3    = 4'd0;
    logic       done  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       fallback;

    int         total = 0;
    int         bad   = 0;
    int         n, pk, hc;
    logic [1:0] pw;
    logic       pfb;
    logic [3:0] exp_g;
    logic [7:0] lfsr_m;

    lottery_bus_arbiter #(.LFSR_SEED(8'hA5), .MAX_HOLD(MAX_HOLD), .MAX_DRAW(MAX_DRAW)) dut (
        .clk(clk), .reset(reset), .req(req), .t0(t0), .t1(t1), .t2(t2), .t3(t3),
        .done(done), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .fallback(fallback)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= 8'hA5;
        else        lfsr_m <= lfsr_step(lfsr_m);
    end

    // Reference draw: k = number of rejected draws before the grant
    function automatic void predict(input logic [7:0] l0, input logic [3:0] rq,
                                    input logic [15:0] tk, output logic [1:0] w,
                                    output int k, output logic fb);
        int tick[4];
        int sum;
        int acc;
        logic [7:0] l;
        bit found;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            tick[i] = rq[i] ? int'(tk[i*4 +: 4]) : 0;
            sum += tick[i];
        end
        if (sum == 0) begin
            for (int i = 0; i < 4; i++) begin
                tick[i] = rq[i] ? 1 : 0;
                sum += tick[i];
            end
        end
        l = l0; w = 2'd0; k = 0; fb = 1'b0; found = 1'b0;
        for (int d = 0; d <= MAX_DRAW && !found; d++) begin
            if (d == MAX_DRAW) begin
                fb = 1'b1;
                for (int i = 3; i >= 0; i--) if (tick[i] != 0) w = 2'(i);
                k = d; found = 1'b1;
            end else if (int'(l[5:0]) < sum) begin
                acc = 0;
                for (int i = 0; i < 4; i++) begin
                    acc += tick[i];
                    if (!found && int'(l[5:0]) < acc) begin
                        w = 2'(i); found = 1'b1;
                    end
                end
                k = d;
            end else begin
                l = lfsr_step(l);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (gnt == 4'd0 && cnt < MAX_DRAW + 3);
    endtask

    // From an IDLE negedge: pass the latching edge, predict, then wait for the grant
    task automatic start_round();
        step();
        predict(lfsr_m, req, {t3, t2, t1, t0}, pw, pk, pfb);
        exp_g = 4'b0001 << pw;
        wait_gnt(n);
    endtask

    task automatic release_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gnt !== 4'd0 || gnt_id !== 2'd0 || busy !== 1'b0 || fallback !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b id=%0d busy=%b fb=%b want 0000 0 0 0", gnt, gnt_id, busy, fallback);
        end
        reset = 1'b1;
        repeat (3) step();
        total++;
        if (gnt !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: gnt=%b busy=%b want 0000 0", gnt, busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0100; t2 = 4'd5;
        start_round();
        total++;
        if (n !== pk + 1 || gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1 || fallback !== pfb) begin
            bad++;
            $display("FAIL single_grant: edges=%0d gnt=%b id=%0d busy=%b fb=%b want edges=%0d gnt=0100 id=2 busy=1 fb=%b",
                     n, gnt, gnt_id, busy, fallback, pk + 1, pfb);
        end
        release_done();
        total++;
        if (gnt !== 4'd0 || busy !== 1'b0 || fallback !== 1'b0) begin
            bad++;
            $display("FAIL single_done_release: gnt=%b busy=%b fb=%b want 0000 0 0", gnt, busy, fallback);
        end
        req = 4'd0; t2 = 4'd0;
    endtask

    task automatic test_equal();
        req = 4'b1111; t0 = 4'd0; t1 = 4'd0; t2 = 4'd0; t3 = 4'd0;
        for (int i = 0; i < 40; i++) begin
            start_round();
            total++;
            if (n !== pk + 1 || gnt !== exp_g || gnt_id !== pw || busy !== 1'b1 || fallback !== pfb) begin
                bad++;
                $display("FAIL equal_round%0d: edges=%0d gnt=%b id=%0d fb=%b busy=%b want edges=%0d gnt=%b id=%0d fb=%b busy=1",
                         i, n, gnt, gnt_id, fallback, busy, pk + 1, exp_g, pw, pfb);
            end
            release_done();
        end
        req = 4'd0;
    endtask

    task automatic test_weighted();
        req = 4'b1111; t0 = 4'd1; t1 = 4'd2; t2 = 4'd4; t3 = 4'd8;
        for (int i = 0; i < 40; i++) begin
            start_round();
            total++;
            if (n !== pk + 1 || gnt !== exp_g || gnt_id !== pw || busy !== 1'b1 || fallback !== pfb) begin
                bad++;
                $display("FAIL weighted_round%0d: edges=%0d gnt=%b id=%0d fb=%b busy=%b want edges=%0d gnt=%b id=%0d fb=%b busy=1",
                         i, n, gnt, gnt_id, fallback, busy, pk + 1, exp_g, pw, pfb);
            end
            release_done();
        end
        req = 4'd0;
    endtask

    task automatic test_zero_ticket();
        int m0;
        m0 = 0;
        req = 4'b0011; t0 = 4'd0; t1 = 4'd1; t2 = 4'd0; t3 = 4'd0;
        for (int i = 0; i < 20; i++) begin
            start_round();
            if (gnt[0] !== 1'b0) m0++;
            total++;
            if (n !== pk + 1 || gnt !== 4'b0010 || gnt_id !== 2'd1 || fallback !== pfb) begin
                bad++;
                $display("FAIL zero_ticket_round%0d: edges=%0d gnt=%b id=%0d fb=%b want edges=%0d gnt=0010 id=1 fb=%b",
                         i, n, gnt, gnt_id, fallback, pk + 1, pfb);
            end
            release_done();
        end
        total++;
        if (m0 !== 0) begin
            bad++;
            $display("FAIL zero_ticket_master0: grants=%0d want 0", m0);
        end
        req = 4'd0;
    endtask

    task automatic test_hold_timeout();
        bit stable;
        req = 4'b0001; t0 = 4'd15; t1 = 4'd0; t2 = 4'd0; t3 = 4'd0;
        start_round();
        hc = 0; stable = 1'b1;
        while (gnt !== 4'd0 && hc < 40) begin
            if (gnt !== exp_g || gnt_id !== pw || busy !== 1'b1) stable = 1'b0;
            hc++;
            step();
        end
        total++;
        if (hc !== MAX_HOLD || stable !== 1'b1) begin
            bad++;
            $display("FAIL hold_timeout: cycles=%0d stable=%b want cycles=%0d stable=1", hc, stable, MAX_HOLD);
        end
        start_round();
        total++;
        if (n !== pk + 1 || gnt !== 4'b0001 || fallback !== pfb) begin
            bad++;
            $display("FAIL hold_regrant: edges=%0d gnt=%b fb=%b want edges=%0d gnt=0001 fb=%b", n, gnt, fallback, pk + 1, pfb);
        end
        repeat (MAX_HOLD - 1) step();
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_last_cycle: gnt=%b busy=%b want 0001 1", gnt, busy);
        end
        release_done();
        total++;
        if (gnt !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_with_timeout: gnt=%b busy=%b want 0000 0", gnt, busy);
        end
        start_round();
        total++;
        if (n !== pk + 1 || gnt !== 4'b0001 || fallback !== pfb) begin
            bad++;
            $display("FAIL post_timeout_regrant: edges=%0d gnt=%b fb=%b want edges=%0d gnt=0001 fb=%b", n, gnt, fallback, pk + 1, pfb);
        end
        release_done();
        req = 4'd0; t0 = 4'd0;
    endtask

    task automatic test_snapshot_drop();
        req = 4'b0011; t0 = 4'd1; t1 = 4'd15; t2 = 4'd0; t3 = 4'd0;
        step();
        predict(lfsr_m, req, {t3, t2, t1, t0}, pw, pk, pfb);
        exp_g = 4'b0001 << pw;
        t0 = 4'd15; t1 = 4'd0;
        wait_gnt(n);
        total++;
        if (n !== pk + 1 || gnt !== exp_g || gnt_id !== pw || fallback !== pfb) begin
            bad++;
            $display("FAIL snapshot_tickets: edges=%0d gnt=%b id=%0d fb=%b want edges=%0d gnt=%b id=%0d fb=%b",
                     n, gnt, gnt_id, fallback, pk + 1, exp_g, pw, pfb);
        end
        release_done();
        req = 4'b0010; t0 = 4'd0; t1 = 4'd3;
        step();
        predict(lfsr_m, req, {t3, t2, t1, t0}, pw, pk, pfb);
        req = 4'd0;
        wait_gnt(n);
        total++;
        if (n !== pk + 1 || gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_in_draw_grant: edges=%0d gnt=%b id=%0d busy=%b want edges=%0d gnt=0010 id=1 busy=1",
                     n, gnt, gnt_id, busy, pk + 1);
        end
        step();
        total++;
        if (gnt !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_in_draw_release: gnt=%b busy=%b want 0000 0", gnt, busy);
        end
        repeat (3) step();
        total++;
        if (gnt !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_stays_idle: gnt=%b busy=%b want 0000 0", gnt, busy);
        end
        t1 = 4'd0;
    endtask

    task automatic test_async_reset();
        req = 4'b1111; t0 = 4'd1; t1 = 4'd2; t2 = 4'd4; t3 = 4'd8;
        start_round();
        total++;
        if (n !== pk + 1 || gnt !== exp_g || fallback !== pfb) begin
            bad++;
            $display("FAIL pre_reset_grant: edges=%0d gnt=%b fb=%b want edges=%0d gnt=%b fb=%b", n, gnt, fallback, pk + 1, exp_g, pfb);
        end
        step();
        #2 reset = 1'b0;
        #1;
        total++;
        if (gnt !== 4'd0 || busy !== 1'b0 || gnt_id !== 2'd0 || fallback !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_drop: gnt=%b busy=%b id=%0d fb=%b want 0000 0 0 0", gnt, busy, gnt_id, fallback);
        end
        @(negedge clk);
        reset = 1'b1;
        // Seed 0xA5 steps to 0x4A: r=10 against sums 1,3,7,15 selects master 3 on the first draw
        start_round();
        total++;
        if (n !== 1 || gnt !== 4'b1000 || gnt_id !== 2'd3 || fallback !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_first_winner: edges=%0d gnt=%b id=%0d fb=%b busy=%b want edges=1 gnt=1000 id=3 fb=0 busy=1",
                     n, gnt, gnt_id, fallback, busy);
        end
        release_done();
        req = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_equal();
        test_weighted();
        test_zero_ticket();
        test_hold_timeout();
        test_snapshot_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
